// File: rtl/resize_pkg.sv
// Shared definitions for the resize stream framer.
// Contents: read-side FSM state type, default output geometry and the
// counter widths derived from it, plus a width helper for parameterised
// instances.
package resize_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VSYNC  = 2'd1,
    ACTIVE = 2'd2,
    HBLANK = 2'd3
  } framer_state_t;

  localparam int RS_WIDTH_OUT  = 1280;
  localparam int RS_HEIGHT_OUT = 720;
  localparam int RS_H_BLANK    = 64;
  localparam int RS_H_PULSE    = 8;
  localparam int RS_V_PULSE    = 16;

  localparam int RS_COL_W = $clog2(RS_WIDTH_OUT);
  localparam int RS_ROW_W = $clog2(RS_HEIGHT_OUT);

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/resize_stream_framer_line_ram.sv
// framer_line_ram: two-bank line buffer, one write port and one read port.
// Address is {bank, col}; the read data is registered (one cycle latency)
// and cleared by reset so the framer output is 0 out of reset.
// Ports:
//   clk, rst          clock, async active-high reset (read register only)
//   we_i, wr_bank_i, wr_col_i, wr_data_i   write port
//   re_i, rd_bank_i, rd_col_i              read address
//   rd_data_o         registered read data
module framer_line_ram #(
  parameter int WIDTH_OUT = 1280,
  parameter int COL_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic             wr_bank_i,
  input  logic [COL_W-1:0] wr_col_i,
  input  logic [7:0]       wr_data_i,
  input  logic             re_i,
  input  logic             rd_bank_i,
  input  logic [COL_W-1:0] rd_col_i,
  output logic [7:0]       rd_data_o
);

  logic [7:0] mem_q [2][WIDTH_OUT];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_bank_i][wr_col_i] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rd_data_q <= '0;
    else if (re_i) rd_data_q <= mem_q[rd_bank_i][rd_col_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/resize_stream_framer.sv
// resize_stream_framer: captures bursty resized pixel lines into a ping-pong
// line buffer and re-emits them as a regular raster with H/V sync.
// Optional feature macro: RESIZE_FRAMER_OVF_EN
//   defined   - pixels arriving for a full bank are dropped, overflow sticky
//   undefined - full banks are overwritten, overflow tied to 0
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_data_en, data_in      input pixel stream
//   data_out, o_data_en      output pixel stream (registered)
//   o_H_SYNC, o_V_SYNC       line / frame sync (registered)
//   overflow                 sticky pixel-dropped flag
//
// state  | meaning
// IDLE   | wait for the read bank to be full
// VSYNC  | frame sync pulse before line 0
// ACTIVE | issue read addresses 0..WIDTH_OUT-1
// HBLANK | blanking, H_SYNC during the first H_PULSE cycles
module resize_stream_framer
  import resize_pkg::*;
#(
  parameter int WIDTH_OUT  = RS_WIDTH_OUT,
  parameter int HEIGHT_OUT = RS_HEIGHT_OUT,
  parameter int H_BLANK    = RS_H_BLANK,
  parameter int H_PULSE    = RS_H_PULSE,
  parameter int V_PULSE    = RS_V_PULSE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_data_en,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       o_data_en,
  output logic       o_H_SYNC,
  output logic       o_V_SYNC,
  output logic       overflow
);

  localparam int COL_W    = cnt_w(WIDTH_OUT);
  localparam int ROW_W    = cnt_w(HEIGHT_OUT);
  localparam int PCNT_MAX = (H_BLANK > V_PULSE) ? H_BLANK : V_PULSE;
  localparam int PCNT_W   = cnt_w(PCNT_MAX + 1);

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH_OUT - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT_OUT - 1);
  localparam logic [PCNT_W-1:0] HB_LAST  = PCNT_W'(H_BLANK - 1);
  localparam logic [PCNT_W-1:0] VP_LAST  = PCNT_W'(V_PULSE - 1);
  localparam logic [PCNT_W-1:0] HP_LEN   = PCNT_W'(H_PULSE);

  // write side
  logic [COL_W-1:0] wr_col_q;
  logic [ROW_W-1:0] wr_row_q;
  logic             wr_bank_q;
  logic [1:0]       bank_full_q, bank_full_d;
  logic             wr_acc, wr_last;

  // read side
  framer_state_t     state_q, state_d;
  logic [COL_W-1:0]  rd_col_q, rd_col_d;
  logic [ROW_W-1:0]  rd_row_q, rd_row_d;
  logic              rd_bank_q, rd_bank_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              rd_en, rd_done;
  logic              en_q, en_d, hs_q, hs_d, vs_q, vs_d;

`ifdef RESIZE_FRAMER_OVF_EN
  logic ovf_q;
  assign wr_acc = in_data_en & ~bank_full_q[wr_bank_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      ovf_q <= 1'b0;
    else if (in_data_en && bank_full_q[wr_bank_q]) ovf_q <= 1'b1;
  end
  assign overflow = ovf_q;
`else
  assign wr_acc   = in_data_en;
  assign overflow = 1'b0;
`endif

  assign wr_last = wr_acc && (wr_col_q == COL_LAST);

  // Set and clear are kept as independent per-bit updates even though the
  // writer and reader never target the same bank in one cycle.
  always_comb begin
    bank_full_d = bank_full_q;
    for (int b = 0; b < 2; b++) begin
      if (wr_last && (wr_bank_q == 1'(b))) bank_full_d[b] = 1'b1;
      if (rd_done && (rd_bank_q == 1'(b))) bank_full_d[b] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_col_q    <= '0;
      wr_row_q    <= '0;
      wr_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
    end else begin
      bank_full_q <= bank_full_d;
      if (wr_acc) begin
        if (wr_col_q == COL_LAST) begin
          wr_col_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
          wr_row_q  <= (wr_row_q == ROW_LAST) ? '0 : wr_row_q + 1'b1;
        end else begin
          wr_col_q <= wr_col_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_col_d  = rd_col_q;
    rd_row_d  = rd_row_q;
    rd_bank_d = rd_bank_q;
    pcnt_d    = pcnt_q;
    rd_en     = 1'b0;
    rd_done   = 1'b0;
    en_d      = 1'b0;
    hs_d      = 1'b0;
    vs_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          pcnt_d  = '0;
          state_d = (rd_row_q == '0) ? VSYNC : ACTIVE;
        end
      end
      VSYNC: begin
        vs_d = 1'b1;
        if (pcnt_q == VP_LAST) begin
          pcnt_d  = '0;
          state_d = ACTIVE;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      ACTIVE: begin
        rd_en = 1'b1;
        en_d  = 1'b1;
        if (rd_col_q == COL_LAST) begin
          rd_col_d  = '0;
          rd_done   = 1'b1;
          rd_bank_d = ~rd_bank_q;
          pcnt_d    = '0;
          state_d   = HBLANK;
        end else begin
          rd_col_d = rd_col_q + 1'b1;
        end
      end
      HBLANK: begin
        hs_d = (pcnt_q < HP_LEN);
        if (pcnt_q == HB_LAST) begin
          pcnt_d   = '0;
          rd_row_d = (rd_row_q == ROW_LAST) ? '0 : rd_row_q + 1'b1;
          state_d  = IDLE;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sync and valid are delayed one cycle so they line up with the
  // registered RAM read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_col_q  <= '0;
      rd_row_q  <= '0;
      rd_bank_q <= 1'b0;
      pcnt_q    <= '0;
      en_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_col_q  <= rd_col_d;
      rd_row_q  <= rd_row_d;
      rd_bank_q <= rd_bank_d;
      pcnt_q    <= pcnt_d;
      en_q      <= en_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  framer_line_ram #(
    .WIDTH_OUT(WIDTH_OUT),
    .COL_W    (COL_W)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wr_acc),
    .wr_bank_i(wr_bank_q),
    .wr_col_i (wr_col_q),
    .wr_data_i(data_in),
    .re_i     (rd_en),
    .rd_bank_i(rd_bank_q),
    .rd_col_i (rd_col_q),
    .rd_data_o(data_out)
  );

  assign o_data_en = en_q;
  assign o_H_SYNC  = hs_q;
  assign o_V_SYNC  = vs_q;

endmodule

// File: tb/tb_resize_stream_framer.sv
module tb_resize_stream_framer;
  localparam int W  = 16;
  localparam int HT = 4;
  localparam int HB = 6;
  localparam int HP = 2;
  localparam int VP = 3;
`ifdef RESIZE_FRAMER_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_data_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       o_data_en, o_H_SYNC, o_V_SYNC, overflow;

  resize_stream_framer #(
    .WIDTH_OUT(W), .HEIGHT_OUT(HT), .H_BLANK(HB), .H_PULSE(HP), .V_PULSE(VP)
  ) dut (
    .clk(clk), .rst(rst), .in_data_en(in_data_en), .data_in(data_in),
    .data_out(data_out), .o_data_en(o_data_en), .o_H_SYNC(o_H_SYNC),
    .o_V_SYNC(o_V_SYNC), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  // Expected output schedule, keyed by cycle index since reset release.
  bit         exp_en  [int];
  logic [7:0] exp_dat [int];
  bit         exp_v   [int];
  bit         exp_h   [int];
  int         line_start [int];
  logic [7:0] cur [W];
  int line_k, acc, rd_free, ovf_from, last_evt;
  int n_en_seen, n_vrise;
  bit prev_v;

  typedef struct {int c; int sig; int val; string nm;} lit_t;
  lit_t lit_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic lit(input int c, input int sig, input int val, input string nm);
    lit_t e;
    e.c = c; e.sig = sig; e.val = val; e.nm = nm;
    lit_q.push_back(e);
  endtask

  task automatic model_reset();
    exp_en.delete(); exp_dat.delete(); exp_v.delete(); exp_h.delete();
    line_start.delete(); lit_q.delete();
    line_k = 0; acc = 0; rd_free = 0; ovf_from = -1; last_evt = 0;
    n_en_seen = 0; n_vrise = 0; prev_v = 1'b0;
  endtask

  // The bank holding line k is busy until line k-2 has been fully read out.
  function automatic bit bank_busy();
    if (line_k < 2) return 1'b0;
    return cyc < line_start[line_k-2] + W - 1;
  endfunction

  task automatic accept(input logic [7:0] d);
    int idle, s;
    cur[acc] = d;
    acc++;
    if (acc == W) begin
      idle = (cyc + 1 > rd_free) ? cyc + 1 : rd_free;
      s = idle + 2 + (((line_k % HT) == 0) ? VP : 0);
      for (int i = 0; i < W; i++) begin
        exp_en[s+i]  = 1'b1;
        exp_dat[s+i] = cur[i];
      end
      if ((line_k % HT) == 0)
        for (int i = 0; i < VP; i++) exp_v[s-VP+i] = 1'b1;
      for (int i = 0; i < HP; i++) exp_h[s+W+i] = 1'b1;
      line_start[line_k] = s;
      rd_free  = s + W - 1 + HB;
      last_evt = rd_free + 2;
      line_k++;
      acc = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    in_data_en = 1'b0;
  endtask

  task automatic send_px(input logic [7:0] d);
    int guard = 0;
    tick();
    while (!OVF && bank_busy()) begin
      guard++;
      if (guard > 5000) begin
        $display("FAIL stall_bound cyc=%0d got=stalled want=bank_free", cyc);
        $fatal(1);
      end
      tick();
    end
    in_data_en = 1'b1;
    data_in    = d;
    if (bank_busy()) begin
      if (ovf_from < 0) ovf_from = cyc + 1;
    end else begin
      accept(d);
    end
  endtask

  task automatic run_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic drain();
    run_until(last_evt + 3);
  endtask

  task automatic do_reset();
    chk_on = 1'b0;
    in_data_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    model_reset();
    chk_on = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [31:0] act;
    if (chk_on && !rst) begin
      chk("en", o_data_en, exp_en.exists(cyc));
      if (exp_en.exists(cyc)) chk("data", data_out, exp_dat[cyc]);
      chk("vsync", o_V_SYNC, exp_v.exists(cyc));
      chk("hsync", o_H_SYNC, exp_h.exists(cyc));
      chk("ovf", overflow, (ovf_from >= 0) && (cyc >= ovf_from));
      if (o_data_en) n_en_seen++;
      if (o_V_SYNC && !prev_v) n_vrise++;
      prev_v = o_V_SYNC;
      foreach (lit_q[i]) begin
        if (lit_q[i].c == cyc) begin
          case (lit_q[i].sig)
            0:       act = 32'(o_data_en);
            1:       act = 32'(data_out);
            2:       act = 32'(o_V_SYNC);
            3:       act = 32'(o_H_SYNC);
            default: act = 32'(overflow);
          endcase
          chk(lit_q[i].nm, act, lit_q[i].val);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  initial begin
    // 1: single line, value = col; check reset state and exact timing.
    do_reset();
    lit(0, 0, 0, "rst_en");   lit(0, 1, 0, "rst_data");
    lit(0, 2, 0, "rst_v");    lit(0, 3, 0, "rst_h");
    lit(0, 4, 0, "rst_ovf");
    lit(18, 2, 0, "l0_v_pre"); lit(19, 2, 1, "l0_v_first"); lit(21, 2, 1, "l0_v_last");
    lit(21, 0, 0, "l0_en_pre"); lit(22, 0, 1, "l0_en_first"); lit(22, 1, 0, "l0_px0");
    lit(37, 1, 15, "l0_px15"); lit(38, 0, 0, "l0_en_post");
    lit(38, 3, 1, "l0_h_first"); lit(39, 3, 1, "l0_h_last"); lit(40, 3, 0, "l0_h_post");
    for (int i = 0; i < W; i++) send_px(8'(i));
    chk("model_start0", line_start[0], 22);
    drain();

    // 2: two lines back to back; second has no V_SYNC, period W+HB+1.
    do_reset();
    lit(42, 2, 0, "l1_no_v"); lit(44, 2, 0, "l1_no_v2");
    lit(44, 0, 0, "l1_en_pre"); lit(45, 1, 8'h22, "l1_px0");
    for (int i = 0; i < W; i++) send_px(8'h11);
    for (int i = 0; i < W; i++) send_px(8'h22);
    chk("model_period", line_start[1] - line_start[0], W + HB + 1);
    drain();

    // 3: three lines back to back; third line hits a full bank.
    do_reset();
    lit(33, 4, 0, "ovf_before");
    lit(34, 4, OVF ? 1 : 0, "ovf_after");
    lit(60, 1, 8'h22, "l1_intact");
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < W; i++) send_px(8'((l + 1) * 8'h11));
`ifdef RESIZE_FRAMER_OVF_EN
    chk("model_ovf_from", ovf_from, 34);
`endif
    drain();

    // 4: full frame plus one line, resizer-like pacing.
    do_reset();
    for (int l = 0; l <= HT; l++) begin
      for (int i = 0; i < W; i++) send_px(8'($urandom));
      repeat (W + W / 2) tick();
    end
    drain();
    chk("frame_pixels", n_en_seen, (HT + 1) * W);
    chk("frame_vpulses", n_vrise, 2);

    // 5: reset in the middle of an output line.
    do_reset();
    for (int i = 0; i < W; i++) send_px(8'hA0 + 8'(i));
    run_until(30);
    chk_on = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_en", o_data_en, 1'b0);
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_v", o_V_SYNC, 1'b0);
    chk("mid_rst_h", o_H_SYNC, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    do_reset();
    lit(21, 2, 1, "post_rst_v");
    for (int i = 0; i < W; i++) send_px(8'h5A ^ 8'(i));
    chk("model_post_rst", line_start[0], 22);
    drain();

    // 6: gapped input, valid every other cycle.
    do_reset();
    for (int i = 0; i < W; i++) begin
      if (i > 0) tick();
      send_px(8'($urandom));
    end
    chk("model_gapped", line_start[0], 37);
    drain();

    // 7: random gaps and data over several frames.
    do_reset();
    for (int l = 0; l < 3 * HT; l++)
      for (int i = 0; i < W; i++) begin
        while ($urandom_range(0, 9) < 3) tick();
        send_px(8'($urandom));
      end
    drain();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
